// File: rtl/seg7_rx_checker_if.sv
// rtl/seg7_rx_checker_if.sv - segment bus in, decoded digit/status out
interface seg7_rx_checker_if #(
    parameter int ERR_W = 8
);
    logic [7:0]       seg_in;
    logic [3:0]       digit;
    logic             dp;
    logic             digit_vld;
    logic             blank;
    logic             pat_err;
    logic             seq_err;
    logic             synced;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output seg_in,
        input  digit, dp, digit_vld, blank, pat_err, seq_err, synced, err_cnt
    );

    modport slave (
        input  seg_in,
        output digit, dp, digit_vld, blank, pat_err, seq_err, synced, err_cnt
    );
endinterface

// File: rtl/seg7_rx_checker.sv
// rtl/seg7_rx_checker.sv - decodes a 7-segment bus, filters glitches, checks +1 counting
module seg7_rx_checker #(
    parameter int STABLE_CYCLES = 3,
    parameter int MODULO        = 10,
    parameter int ERR_W         = 8
) (
    input  logic clk,
    input  logic rst,
    seg7_rx_checker_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [3:0]    LAST_DIGIT = 4'(MODULO - 1);

    typedef enum logic {UNSYNC, SYNC} state_t;

    state_t           state;
    logic [7:0]       seg_q;
    logic [7:0]       cand;
    logic [SW-1:0]    stab;
    logic [7:0]       last;
    logic [3:0]       digit;
    logic             dp;
    logic             digit_vld;
    logic             blank;
    logic             pat_err;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;

    logic             seg_diff;
    logic [7:0]       cand_nxt;
    logic [SW-1:0]    stab_nxt;
    logic             accept;
    logic [3:0]       dec_val;
    logic             dec_hit;
    logic             dec_digit;
    logic             dec_blank;
    logic [3:0]       exp_next;

    // Acceptance fires only on the edge the counter first reaches the threshold,
    // so a saturated candidate never re-triggers.
    always_comb begin
        seg_diff = (seg_q != cand);
        cand_nxt = seg_diff ? seg_q : cand;
        if (seg_diff)
            stab_nxt = SW'(1);
        else if (stab == STAB_MAX)
            stab_nxt = stab;
        else
            stab_nxt = stab + SW'(1);
        accept = (stab_nxt == STAB_MAX) && (seg_diff || stab != STAB_MAX)
                 && (cand_nxt != last);
    end

    always_comb begin
        dec_val = 4'd0;
        dec_hit = 1'b1;
        case (cand_nxt[6:0])
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            default: dec_hit = 1'b0;
        endcase
        dec_digit = dec_hit && (32'(dec_val) < MODULO);
        dec_blank = (cand_nxt[6:0] == 7'h00);
        exp_next  = (digit == LAST_DIGIT) ? 4'd0 : digit + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= UNSYNC;
            seg_q     <= 8'h00;
            cand      <= 8'h00;
            stab      <= '0;
            last      <= 8'h00;
            digit     <= 4'd0;
            dp        <= 1'b0;
            digit_vld <= 1'b0;
            blank     <= 1'b1;
            pat_err   <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            seg_q     <= bus.seg_in;
            cand      <= cand_nxt;
            stab      <= stab_nxt;
            digit_vld <= 1'b0;
            pat_err   <= 1'b0;
            seq_err   <= 1'b0;
            if (accept) begin
                last <= cand_nxt;
                if (dec_digit) begin
                    digit     <= dec_val;
                    dp        <= cand_nxt[7];
                    blank     <= 1'b0;
                    digit_vld <= 1'b1;
                    if (state == SYNC && dec_val != exp_next) begin
                        seq_err <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + ERR_W'(1);
                    end
                    state <= SYNC;
                end else if (dec_blank) begin
                    blank <= 1'b1;
                    state <= UNSYNC;
                end else begin
                    pat_err <= 1'b1;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + ERR_W'(1);
                    state <= UNSYNC;
                end
            end
        end
    end

    assign bus.digit     = digit;
    assign bus.dp        = dp;
    assign bus.digit_vld = digit_vld;
    assign bus.blank     = blank;
    assign bus.pat_err   = pat_err;
    assign bus.seq_err   = seq_err;
    assign bus.synced    = (state == SYNC);
    assign bus.err_cnt   = err_cnt;
endmodule
